regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised successor to the 32x32 register file used in the MIPS datapath.
- Two registered read ports and one write port, all on a single rising clock edge.
- Adds write enable, hardwired-zero register 0, optional write-to-read bypass, per-port read enable, and a reset-driven clear sweep that zeroes every register.
- Sits between the decode stage (read addresses) and the writeback stage (write address and data).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width. Depth is DEPTH = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 always reads 0 and writes to it are dropped.
- BYPASS, 1, when 1 a same-cycle write to a read address is forwarded to that read port.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- rd_en1  in  1  read port 1 enable.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_data1  out  DATA_W  read port 1 data, registered.
- rd_en2  in  1  read port 2 enable.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data2  out  DATA_W  read port 2 data, registered.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- busy  out  1  high while the clear sweep runs; port accesses are ignored while high.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: in the cycle after rst is sampled high, rd_data1=0, rd_data2=0, busy=1, FSM state=CLEAR, sweep index=0.
- FSM states:
  - CLEAR: each cycle, write 0 to mem[idx], then idx <= idx+1. When idx==DEPTH-1 has been cleared, go to READY; busy falls on that same edge.
  - READY: normal operation. Stays in READY until rst is asserted.
- Sweep length: busy is high for exactly DEPTH cycles after rst deasserts (32 with the defaults). Holding rst high keeps idx=0 and busy=1.
- Reset mid-operation, including mid-sweep: the sweep restarts at idx 0. Any in-flight write on that edge is dropped.
- Writes while busy=1: ignored; wr_en has no effect.
- Reads while busy=1: rd_data1/2 are forced to 0.
- Write in READY: if wr_en=1, mem[wr_addr] <= wr_data on the rising edge. If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read latency: 1 cycle. If rd_enN=1 at edge k, rd_dataN at edge k+1 reflects mem[rd_addrN].
- Read disable: if rd_enN=0, rd_dataN holds its previous value.
- Zero register: if ZERO_REG=1 and rd_addrN=0, rd_dataN <= 0 regardless of memory contents or any bypass.
- Simultaneous write and read of the same address (wr_en=1, rd_enN=1, wr_addr==rd_addrN, READY):
  - BYPASS=1: rd_dataN <= wr_data, the new value.
  - BYPASS=0: rd_dataN <= the old contents.
- Port independence: both read ports may use the same address; each is evaluated independently.
- Widths: no arithmetic. Data passes through unmodified, with no sign handling; full DATA_W bits are stored.
- Memory contents are never loaded from a file. The sweep is the only initialisation.

Test Plan:
1. Clear sweep: pulse rst for 1 cycle -> busy=1 for exactly 32 cycles then 0. After that, reading addresses 0..31 returns 0 on all of them.
2. Basic write/read: write 0xDEADBEEF to addr 5. Next cycle rd_en1=1, rd_addr1=5 -> rd_data1=0xDEADBEEF one cycle later. rd_addr2=6 -> rd_data2=0.
3. Zero register: write 0x12345678 to addr 0, then read addr 0 on both ports -> 0 on both. Repeat with ZERO_REG=0 -> 0x12345678.
4. Bypass: write 0xA5A5A5A5 to addr 9 while addr 9 holds 0x1, with both ports reading addr 9 in the same cycle -> both ports return 0xA5A5A5A5 when BYPASS=1, and 0x00000001 when BYPASS=0.
5. Read hold and busy gating:
   - rd_en1=0 with a changing rd_addr1 -> rd_data1 unchanged.
   - During the sweep, wr_en=1 to addr 3 with 0xFFFF0000 -> addr 3 reads 0 after the sweep.
6. Reset mid-sweep: assert rst at sweep cycle 10 -> busy stays high for a full 32 cycles after rst releases. A value written before the reset reads 0 afterwards.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file: two registered read ports and one write port.
// Adds a reset-driven clear sweep, an optional hardwired zero register and optional write-to-read bypass.
module regfile_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en1,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic              rd_en2,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_busy;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_wr_ok;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // Writes to register 0 are dropped when it is hardwired to zero.
    assign w_wr_ok = (r_state == S_READY) && wr_en && !(ZERO_REG && (wr_addr == '0));

    // Read-port next values: memory, then bypass, with the zero register taking priority.
    always_comb begin
        w_rd1 = r_mem[rd_addr1];
        if (BYPASS && w_wr_ok && (wr_addr == rd_addr1)) begin
            w_rd1 = wr_data;
        end
        if (ZERO_REG && (rd_addr1 == '0)) begin
            w_rd1 = '0;
        end
    end

    always_comb begin
        w_rd2 = r_mem[rd_addr2];
        if (BYPASS && w_wr_ok && (wr_addr == rd_addr2)) begin
            w_rd2 = wr_data;
        end
        if (ZERO_REG && (rd_addr2 == '0)) begin
            w_rd2 = '0;
        end
    end

    // Clear sweep after reset, then normal read/write operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_rd1   <= '0;
            r_rd2   <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_mem[r_idx] <= '0;
                    r_idx        <= r_idx + ADDR_W'(1);
                    r_rd1        <= '0;
                    r_rd2        <= '0;
                    if (r_idx == ADDR_W'(DEPTH - 1)) begin
                        r_state <= S_READY;
                        r_busy  <= 1'b0;
                    end
                end
                S_READY: begin
                    if (w_wr_ok) begin
                        r_mem[wr_addr] <= wr_data;
                    end
                    if (rd_en1) begin
                        r_rd1 <= w_rd1;
                    end
                    if (rd_en2) begin
                        r_rd2 <= w_rd2;
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_idx   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign rd_data1 = r_rd1;
    assign rd_data2 = r_rd2;
    assign busy     = r_busy;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two instances (zero-reg+bypass, and neither) driven by the same stimulus,
// checked each cycle against an array-based reference model plus directed constant checks.
module tb_regfile_param;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_en1, rd_en2, wr_en;
    logic [ADDR_W-1:0] rd_addr1, rd_addr2, wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic              a_busy, b_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_a (
        .clk(clk), .rst(rst),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(a_rd1),
        .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(a_rd2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(a_busy)
    );

    regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut_b (
        .clk(clk), .rst(rst),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(b_rd1),
        .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(b_rd2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(b_busy)
    );

    // Reference model: index 0 = zero-reg+bypass instance, index 1 = plain instance.
    logic [DATA_W-1:0] m_mem [2][DEPTH];
    logic [DATA_W-1:0] m_rd1 [2];
    logic [DATA_W-1:0] m_rd2 [2];
    bit                m_zr  [2] = '{1'b1, 1'b0};
    bit                m_bp  [2] = '{1'b1, 1'b0};
    int                m_left = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] m_read(input int k, input logic [ADDR_W-1:0] a);
        if (m_zr[k] && a == '0) return '0;
        if (m_bp[k] && wr_en && wr_addr == a) return wr_data;
        return m_mem[k][a];
    endfunction

    // Advance the model with the current inputs, clock once, and compare all outputs.
    task automatic step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < int'(DEPTH); i++) m_mem[k][i] = '0;
                m_rd1[k] = '0;
                m_rd2[k] = '0;
            end else if (m_left > 0) begin
                m_rd1[k] = '0;
                m_rd2[k] = '0;
            end else begin
                if (rd_en1) m_rd1[k] = m_read(k, rd_addr1);
                if (rd_en2) m_rd2[k] = m_read(k, rd_addr2);
                if (wr_en && !(m_zr[k] && wr_addr == '0)) m_mem[k][wr_addr] = wr_data;
            end
        end
        if (rst) m_left = int'(DEPTH);
        else if (m_left > 0) m_left--;
        @(posedge clk);
        #1;
        chk("busy_a", 32'(a_busy), 32'(m_left > 0));
        chk("busy_b", 32'(b_busy), 32'(m_left > 0));
        chk("rd1_a", a_rd1, m_rd1[0]);
        chk("rd2_a", a_rd2, m_rd2[0]);
        chk("rd1_b", b_rd1, m_rd1[1]);
        chk("rd2_b", b_rd2, m_rd2[1]);
    endtask

    task automatic idle();
        rst = 1'b0; rd_en1 = 1'b0; rd_en2 = 1'b0; wr_en = 1'b0;
        rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; wr_data = '0;
    endtask

    // Count busy-high samples from the reset edge on; stops writing once busy drops.
    task automatic count_sweep(output int bc);
        bc = a_busy ? 1 : 0;
        for (int c = 0; c < 40; c++) begin
            if (!a_busy) wr_en = 1'b0;
            step();
            if (a_busy) bc++;
        end
    endtask

    function automatic logic [ADDR_W-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return ADDR_W'($urandom_range(0, 3));
        return ADDR_W'($urandom);
    endfunction

    initial begin
        int bc;
        idle();
        rst = 1'b1;

        // Reset and clear sweep
        step();
        chk("reset_rd1", a_rd1, 32'h0);
        chk("reset_busy", 32'(a_busy), 32'h1);
        rst = 1'b0;
        count_sweep(bc);
        chk("sweep_len", 32'(bc), 32'd32);
        for (int a = 0; a < int'(DEPTH); a++) begin
            rd_en1 = 1'b1; rd_addr1 = ADDR_W'(a);
            rd_en2 = 1'b1; rd_addr2 = ADDR_W'(31 - a);
            step();
            chk("cleared_b1", b_rd1, 32'h0);
            chk("cleared_b2", b_rd2, 32'h0);
        end

        // Basic write then read
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        step();
        idle();
        rd_en1 = 1'b1; rd_addr1 = 5'd5; rd_en2 = 1'b1; rd_addr2 = 5'd6;
        step();
        chk("wr_rd5", a_rd1, 32'hDEADBEEF);
        chk("rd6_zero", a_rd2, 32'h0);

        // Zero register
        idle();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        step();
        idle();
        rd_en1 = 1'b1; rd_en2 = 1'b1;
        step();
        chk("zr_a1", a_rd1, 32'h0);
        chk("zr_a2", a_rd2, 32'h0);
        chk("nozr_b1", b_rd1, 32'h12345678);
        chk("nozr_b2", b_rd2, 32'h12345678);

        // Same-cycle write/read bypass
        idle();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1;
        step();
        wr_data = 32'hA5A5A5A5;
        rd_en1 = 1'b1; rd_addr1 = 5'd9; rd_en2 = 1'b1; rd_addr2 = 5'd9;
        step();
        chk("byp_a1", a_rd1, 32'hA5A5A5A5);
        chk("byp_a2", a_rd2, 32'hA5A5A5A5);
        chk("nobyp_b1", b_rd1, 32'h00000001);
        chk("nobyp_b2", b_rd2, 32'h00000001);

        // Read hold with changing address
        idle();
        rd_en1 = 1'b1; rd_addr1 = 5'd5;
        step();
        rd_en1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_addr1 = ADDR_W'(i + 6);
            step();
            chk("rd_hold", a_rd1, 32'hDEADBEEF);
        end

        // Reset mid-sweep with writes attempted throughout the sweep
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF0000;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_sweep(bc);
        chk("resweep_len", 32'(bc), 32'd32);
        idle();
        rd_en1 = 1'b1; rd_addr1 = 5'd3; rd_en2 = 1'b1; rd_addr2 = 5'd5;
        step();
        chk("busy_wr_dropped", b_rd1, 32'h0);
        chk("pre_reset_cleared", b_rd2, 32'h0);

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 299) == 0);
            rd_en1   = ($urandom_range(0, 3) != 0);
            rd_en2   = ($urandom_range(0, 3) != 0);
            wr_en    = ($urandom_range(0, 1) == 0);
            rd_addr1 = rnd_addr();
            rd_addr2 = rnd_addr();
            wr_addr  = rnd_addr();
            wr_data  = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
